buffer_tile_streamer: RTL

Read-side client of the tiled activation/weight buffer file. On a start command it walks one buffer tile by tile, driving the buffer's read strobe, index-reset and buffer-select inputs. It captures each returned TILE_ELEMS-wide tile and serialises it as a valid/ready element stream toward the downstream compute units (MAC/ReLU/output path).

---
 rtl/buffer_tile_streamer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/buffer_tile_streamer.sv
// Read-side client of the tiled buffer file: fetches one buffer tile at a time
// and serialises each tile as a valid/ready element stream.
module buffer_tile_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_ELEMS   = 32,
  parameter int BUFFER_COUNT = 2,
  parameter int MAX_TILES    = 32,
  parameter int LEN_WIDTH    = $clog2(MAX_TILES * TILE_ELEMS) + 1,
  parameter int SEL_WIDTH    = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  buf_sel,
  input  logic [LEN_WIDTH-1:0]  num_elems,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_read_enable,
  output logic [SEL_WIDTH-1:0]  buf_read_buffer,
  output logic                  buf_reset_indices_enable,
  output logic [SEL_WIDTH-1:0]  buf_reset_indices_buffer,
  input  logic [DATA_WIDTH-1:0] buf_read_data [TILE_ELEMS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [LEN_WIDTH-1:0]  out_index,
  output logic [2:0]            dbg_state
);

  localparam int PTR_WIDTH = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_TILES * TILE_ELEMS);
  localparam logic [PTR_WIDTH-1:0] LAST_LANE = PTR_WIDTH'(TILE_ELEMS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t                  state;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [PTR_WIDTH-1:0]    elem_ptr;
  logic                    first_tile;
  logic [DATA_WIDTH-1:0]   tile [TILE_ELEMS];
  logic [LEN_WIDTH-1:0]    start_len;
  logic                    handshake;

  // Stream handshake: an element transfers in any cycle where out_valid and
  // out_ready are both high; out_valid never drops and out_data/out_last/
  // out_index never change until that transfer happens.
  assign handshake = out_valid && out_ready;

  // Oversized requests are clamped so reads never pass the last tile.
  assign start_len = (num_elems > MAX_LEN) ? MAX_LEN : num_elems;

  assign out_data  = out_valid ? tile[elem_ptr] : '0;
  assign out_last  = out_valid && (remaining == LEN_WIDTH'(1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= IDLE;
      sel_q                    <= '0;
      remaining                <= '0;
      elem_ptr                 <= '0;
      first_tile               <= 1'b0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
      buf_read_enable          <= 1'b0;
      buf_read_buffer          <= '0;
      buf_reset_indices_enable <= 1'b0;
      buf_reset_indices_buffer <= '0;
      out_valid                <= 1'b0;
      out_index                <= '0;
      for (int i = 0; i < TILE_ELEMS; i++) tile[i] <= '0;
    end else begin
      // Strobes default low; they are raised only on entry to FETCH/FINISH.
      done                     <= 1'b0;
      buf_read_enable          <= 1'b0;
      buf_read_buffer          <= '0;
      buf_reset_indices_enable <= 1'b0;
      buf_reset_indices_buffer <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            out_index <= '0;
            if (start_len == '0) begin
              state <= FINISH;
            end else begin
              sel_q                    <= buf_sel;
              remaining                <= start_len;
              elem_ptr                 <= '0;
              first_tile               <= 1'b1;
              state                    <= FETCH;
              buf_read_enable          <= 1'b1;
              buf_read_buffer          <= buf_sel;
              buf_reset_indices_enable <= 1'b1;
              buf_reset_indices_buffer <= buf_sel;
            end
          end
        end

        FETCH: begin
          first_tile <= 1'b0;
          state      <= CAPTURE;
        end

        CAPTURE: begin
          for (int i = 0; i < TILE_ELEMS; i++) tile[i] <= buf_read_data[i];
          out_valid <= 1'b1;
          state     <= DRAIN;
        end

        DRAIN: begin
          if (handshake) begin
            elem_ptr  <= (elem_ptr == LAST_LANE) ? '0 : elem_ptr + PTR_WIDTH'(1);
            out_index <= out_index + LEN_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              out_valid <= 1'b0;
              state     <= FINISH;
            end else if (elem_ptr == LAST_LANE) begin
              out_valid                <= 1'b0;
              state                    <= FETCH;
              buf_read_enable          <= 1'b1;
              buf_read_buffer          <= sel_q;
              buf_reset_indices_enable <= first_tile;
              buf_reset_indices_buffer <= first_tile ? sel_q : '0;
            end
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
